// File: rtl/wb_regfile.sv
// Writeback register file: commits EX_WB results into NUM_REGS flop-based registers, returns
// registered operands with write-first bypass, and emits a commit trace and retired-op counter.
// ex_wb_reg layout (MSB..LSB): {alu_result[XLEN-1:0], alu_result_ready, reg_wr_addr[ADDR_W-1:0], reg_wr_en}
module wb_regfile #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [XLEN+ADDR_W+1:0]   ex_wb_reg,
    input  logic [ADDR_W-1:0]        rs1_addr,
    input  logic [ADDR_W-1:0]        rs2_addr,
    input  logic                     rd_req,
    output logic [XLEN-1:0]          alu_reg_input_a,
    output logic [XLEN-1:0]          alu_reg_input_b,
    output logic                     wb_valid,
    output logic [ADDR_W-1:0]        wb_addr,
    output logic [XLEN-1:0]          wb_data,
    output logic [31:0]              retired_count
);

    logic [XLEN-1:0]   alu_result_s;
    logic              accept_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic              wr_en_s;
    logic              commit_s;
    logic [XLEN-1:0]   op_a_s;
    logic [XLEN-1:0]   op_b_s;
    logic [XLEN-1:0]   regs_r [NUM_REGS];

    assign alu_result_s = ex_wb_reg[XLEN+ADDR_W+1:ADDR_W+2];
    assign accept_s     = ex_wb_reg[ADDR_W+1];
    assign wr_addr_s    = ex_wb_reg[ADDR_W:1];
    assign wr_en_s      = ex_wb_reg[0];
    assign commit_s     = accept_s && wr_en_s && (wr_addr_s != {ADDR_W{1'b0}});

    // Operand selection: x0 reads zero, a same-edge commit wins over stored contents.
    always_comb begin
        op_a_s = {XLEN{1'b0}};
        op_b_s = {XLEN{1'b0}};
        if (rs1_addr == {ADDR_W{1'b0}}) begin
            op_a_s = {XLEN{1'b0}};
        end else if (commit_s && (wr_addr_s == rs1_addr)) begin
            op_a_s = alu_result_s;
        end else begin
            op_a_s = regs_r[rs1_addr];
        end
        if (rs2_addr == {ADDR_W{1'b0}}) begin
            op_b_s = {XLEN{1'b0}};
        end else if (commit_s && (wr_addr_s == rs2_addr)) begin
            op_b_s = alu_result_s;
        end else begin
            op_b_s = regs_r[rs2_addr];
        end
    end

    // Register file storage; entry 0 is never written because commit excludes address 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (commit_s) begin
            regs_r[wr_addr_s] <= alu_result_s;
        end
    end

    // Operand outputs: sampled on rd_req, otherwise held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_reg_input_a <= {XLEN{1'b0}};
            alu_reg_input_b <= {XLEN{1'b0}};
        end else if (rd_req) begin
            alu_reg_input_a <= op_a_s;
            alu_reg_input_b <= op_b_s;
        end
    end

    // Commit trace and retired counter; trace address/data follow the bus every cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid      <= 1'b0;
            wb_addr       <= {ADDR_W{1'b0}};
            wb_data       <= {XLEN{1'b0}};
            retired_count <= 32'd0;
        end else begin
            wb_valid <= commit_s;
            wb_addr  <= wr_addr_s;
            wb_data  <= alu_result_s;
            if (accept_s) begin
                retired_count <= retired_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: vector table plus hand sequences, expectations via a queue.
module tb_wb_regfile;

    logic        clk;
    logic        reset_n;
    logic [38:0] ex_wb_reg;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rd_req;
    logic [31:0] alu_reg_input_a;
    logic [31:0] alu_reg_input_b;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] retired_count;

    wb_regfile dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .ex_wb_reg       (ex_wb_reg),
        .rs1_addr        (rs1_addr),
        .rs2_addr        (rs2_addr),
        .rd_req          (rd_req),
        .alu_reg_input_a (alu_reg_input_a),
        .alu_reg_input_b (alu_reg_input_b),
        .wb_valid        (wb_valid),
        .wb_addr         (wb_addr),
        .wb_data         (wb_data),
        .retired_count   (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ready;
        logic        en;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        valid;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] count;
    } exp_t;

    exp_t        exp_q[$];
    vec_t        vecs[10];
    int          n_checks;
    int          n_fail;
    logic [31:0] model_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one cycle at the falling edge, queue the expectation, check after the rising edge.
    task automatic step(input logic ready, input logic en, input logic [4:0] waddr,
                        input logic [31:0] wdata, input logic rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] ea, input logic [31:0] eb);
        exp_t e;
        exp_t g;
        @(negedge clk);
        ex_wb_reg = {wdata, ready, waddr, en};
        rd_req    = rd;
        rs1_addr  = rs1;
        rs2_addr  = rs2;
        if (ready) model_count = model_count + 32'd1;
        e.a     = ea;
        e.b     = eb;
        e.valid = ready && en && (waddr != 5'd0);
        e.addr  = waddr;
        e.data  = wdata;
        e.count = model_count;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        g = exp_q.pop_front();
        chk("operand_a", alu_reg_input_a, g.a);
        chk("operand_b", alu_reg_input_b, g.b);
        chk("wb_valid", {31'd0, wb_valid}, {31'd0, g.valid});
        chk("wb_addr", {27'd0, wb_addr}, {27'd0, g.addr});
        chk("wb_data", wb_data, g.data);
        chk("retired_count", retired_count, g.count);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a"}, alu_reg_input_a, 32'd0);
        chk({tag, "_b"}, alu_reg_input_b, 32'd0);
        chk({tag, "_valid"}, {31'd0, wb_valid}, 32'd0);
        chk({tag, "_addr"}, {27'd0, wb_addr}, 32'd0);
        chk({tag, "_data"}, wb_data, 32'd0);
        chk({tag, "_count"}, retired_count, 32'd0);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        model_count = 32'd0;
        reset_n     = 1'b0;
        ex_wb_reg   = 39'd0;
        rs1_addr    = 5'd0;
        rs2_addr    = 5'd0;
        rd_req      = 1'b0;

        //          ready  en    waddr  wdata          rd    rs1    rs2    exp_a          exp_b
        vecs[0] = '{1'b1, 1'b1, 5'd7,  32'h12345678, 1'b1, 5'd5,  5'd31, 32'h00000000, 32'h00000000};
        vecs[1] = '{1'b0, 1'b0, 5'd0,  32'h00000000, 1'b1, 5'd7,  5'd0,  32'h12345678, 32'h00000000};
        vecs[2] = '{1'b1, 1'b1, 5'd3,  32'hCAFEF00D, 1'b1, 5'd3,  5'd3,  32'hCAFEF00D, 32'hCAFEF00D};
        vecs[3] = '{1'b1, 1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  5'd3,  32'h00000000, 32'hCAFEF00D};
        vecs[4] = '{1'b1, 1'b0, 5'd3,  32'hDEAD0000, 1'b1, 5'd3,  5'd7,  32'hCAFEF00D, 32'h12345678};
        vecs[5] = '{1'b0, 1'b1, 5'd3,  32'h00000055, 1'b1, 5'd3,  5'd0,  32'hCAFEF00D, 32'h00000000};
        vecs[6] = '{1'b1, 1'b1, 5'd31, 32'hA5A5A5A5, 1'b1, 5'd31, 5'd7,  32'hA5A5A5A5, 32'h12345678};
        vecs[7] = '{1'b1, 1'b1, 5'd7,  32'h00000011, 1'b1, 5'd7,  5'd31, 32'h00000011, 32'hA5A5A5A5};
        vecs[8] = '{1'b1, 1'b1, 5'd7,  32'h00000022, 1'b0, 5'd7,  5'd7,  32'h00000011, 32'hA5A5A5A5};
        vecs[9] = '{1'b0, 1'b0, 5'd0,  32'h00000000, 1'b1, 5'd7,  5'd1,  32'h00000022, 32'h00000000};

        // Outputs while reset is held, including across a rising edge.
        #1;
        chk_zero("reset_hold");
        @(posedge clk);
        #1;
        chk_zero("reset_edge");
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step(vecs[i].ready, vecs[i].en, vecs[i].waddr, vecs[i].wdata,
                 vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].ea, vecs[i].eb);
        end

        // Ten commits with operands held, then reset pulsed between edges.
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 1'b1, 5'(i), 32'h1000 + 32'(i), 1'b0, 5'd0, 5'd0,
                 32'h00000022, 32'h00000000);
        end
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd10, 32'h00001005, 32'h0000100A);
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("async_reset");
        model_count = 32'd0;

        // Commit presented while reset is held across an edge must be lost.
        @(negedge clk);
        ex_wb_reg = {32'hBEEF0004, 1'b1, 5'd4, 1'b1};
        rd_req    = 1'b1;
        rs1_addr  = 5'd4;
        rs2_addr  = 5'd4;
        @(posedge clk);
        #1;
        chk_zero("reset_commit");
        @(negedge clk);
        reset_n   = 1'b1;
        ex_wb_reg = 39'd0;

        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd10, 32'd0, 32'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd31, 32'd0, 32'd0);
        step(1'b1, 1'b1, 5'd9, 32'h0BADF00D, 1'b1, 5'd9, 5'd1, 32'h0BADF00D, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
